// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the button-press detector: state codes, default
// debounce length and the one-hot test on a captured button sample.
package detector_jogada_pkg;

  localparam int DEBOUNCE_DEFAULT = 50000;
  localparam int NUM_BOTOES       = 4;

  // 4-bit codes are also what the hexa7seg display mux shows
  typedef enum logic [3:0] {
    OCIOSO        = 4'd0,
    FILTRANDO     = 4'd1,
    EMITE         = 4'd2,
    ESPERA_SOLTAR = 4'd3
  } estado_t;

  function automatic logic eh_one_hot(input logic [NUM_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - NUM_BOTOES'(1))) == '0);
  endfunction

endpackage

// File: rtl/detector_jogada_sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; also reused for iniciar.
module sincronizador_2ff #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [1:0][W-1:0] sync_pipe;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], d};
  end

  assign q = sync_pipe[1];

endmodule

// File: rtl/detector_jogada.sv
// Synchronizes and debounces four push-buttons; one jogada_feita pulse per
// one-hot press, multiplo pulse for multi-button presses, release is debounced too.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_BOTOES-1:0] botoes_in,
  input  logic                  habilita,
  output logic                  jogada_feita,
  output logic [NUM_BOTOES-1:0] jogada,
  output logic                  multiplo,
  output logic [3:0]            db_estado
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BOTOES-1:0] sinc;
  logic [NUM_BOTOES-1:0] amostra;
  logic [CNT_W-1:0]      cnt;
  estado_t               estado;
  logic                  amostra_1h;

  sincronizador_2ff #(.W(NUM_BOTOES)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (botoes_in),
    .q     (sinc)
  );

  assign amostra_1h = eh_one_hot(amostra);
  assign db_estado  = estado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= OCIOSO;
      amostra      <= '0;
      cnt          <= '0;
      jogada       <= '0;
      jogada_feita <= 1'b0;
      multiplo     <= 1'b0;
    end else begin
      jogada_feita <= 1'b0;
      multiplo     <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (habilita && sinc != '0) begin
            amostra <= sinc;
            cnt     <= '0;
            estado  <= FILTRANDO;
          end
        end
        FILTRANDO: begin
          // any change of the sampled pattern is treated as bounce and discarded
          if (!habilita || sinc != amostra) begin
            estado <= OCIOSO;
          end else if (cnt == CNT_MAX) begin
            estado <= EMITE;
            if (amostra_1h) begin
              jogada_feita <= 1'b1;
              jogada       <= amostra;
            end else begin
              multiplo <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        EMITE: begin
          cnt    <= '0;
          estado <= ESPERA_SOLTAR;
        end
        ESPERA_SOLTAR: begin
          // release must be seen as a full debounce window of all-zero input
          if (sinc != '0)            cnt    <= '0;
          else if (cnt == CNT_MAX)   estado <= OCIOSO;
          else                       cnt    <= cnt + CNT_W'(1);
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with DEBOUNCE_CYCLES = 4.
module tb_detector_jogada;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes_in;
  logic       habilita;
  logic       jogada_feita;
  logic [3:0] jogada;
  logic       multiplo;
  logic [3:0] db_estado;

  int tests = 0, fails = 0;
  int pulses = 0, mults = 0, both = 0;

  detector_jogada #(.DEBOUNCE_CYCLES(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes_in    (botoes_in),
    .habilita     (habilita),
    .jogada_feita (jogada_feita),
    .jogada       (jogada),
    .multiplo     (multiplo),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] b;
    logic       h;
    logic [3:0] st;
    logic       f;
    logic [3:0] j;
    logic       m;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(logic [3:0] b, logic h, logic [3:0] st,
                              logic f, logic [3:0] j, logic m);
    vec_t v;
    v.b = b; v.h = h; v.st = st; v.f = f; v.j = j; v.m = m;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (jogada_feita) pulses++;
    if (multiplo) mults++;
    if (jogada_feita && multiplo) both++;
  endtask

  task automatic wait_idle(input int max);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      step();
      if (db_estado == 4'd0) begin ok = 1'b1; break; end
    end
    chk("wait_idle", ok, 1'b1);
  endtask

  task automatic wait_pulse(input int max, output int n);
    n = -1;
    for (int k = 1; k <= max; k++) begin
      step();
      if (jogada_feita) begin n = k; break; end
    end
  endtask

  initial begin
    int n;

    tbl[0] = mk(4'b0100, 1'b1, 4'd0, 1'b0, 4'b0000, 1'b0);
    tbl[1] = mk(4'b0100, 1'b1, 4'd0, 1'b0, 4'b0000, 1'b0);
    for (int i = 2; i <= 5; i++) tbl[i] = mk(4'b0100, 1'b1, 4'd1, 1'b0, 4'b0000, 1'b0);
    tbl[6] = mk(4'b0100, 1'b1, 4'd2, 1'b1, 4'b0100, 1'b0);
    for (int i = 7; i <= 19; i++) tbl[i] = mk(4'b0100, 1'b1, 4'd3, 1'b0, 4'b0100, 1'b0);
    for (int i = 20; i <= 24; i++) tbl[i] = mk(4'b0000, 1'b1, 4'd3, 1'b0, 4'b0100, 1'b0);
    tbl[25] = mk(4'b0000, 1'b1, 4'd0, 1'b0, 4'b0100, 1'b0);

    reset = 1'b0; botoes_in = 4'b0000; habilita = 1'b0;
    step(); step();
    chk("rst estado", db_estado, 4'd0);
    chk("rst jogada", jogada, 4'b0000);
    chk("rst feita", jogada_feita, 1'b0);
    chk("rst multiplo", multiplo, 1'b0);
    reset = 1'b1;
    step();

    // clean press: pulse 7 edges after raw change, state walk 0,1,2,3,0
    pulses = 0;
    foreach (tbl[i]) begin
      botoes_in = tbl[i].b;
      habilita  = tbl[i].h;
      step();
      chk($sformatf("vec%0d estado", i), db_estado, tbl[i].st);
      chk($sformatf("vec%0d feita", i), jogada_feita, tbl[i].f);
      chk($sformatf("vec%0d jogada", i), jogada, tbl[i].j);
      chk($sformatf("vec%0d multiplo", i), multiplo, tbl[i].m);
    end
    chk("clean pulses", pulses, 1);

    // bounce during filtering aborts, stable retry gives one pulse
    pulses = 0;
    botoes_in = 4'b0010; step(); step();
    botoes_in = 4'b0000; step();
    chk("bounce filtering", db_estado, 4'd1);
    botoes_in = 4'b0010; step(); step();
    chk("bounce abort", db_estado, 4'd0);
    chk("bounce no pulse yet", pulses, 0);
    repeat (10) step();
    chk("bounce pulses", pulses, 1);
    chk("bounce jogada", jogada, 4'b0010);
    botoes_in = 4'b0000;
    wait_idle(20);

    // two buttons: multiplo only, jogada unchanged
    pulses = 0; mults = 0;
    botoes_in = 4'b1001;
    repeat (10) step();
    chk("multi multiplo", mults, 1);
    chk("multi no feita", pulses, 0);
    chk("multi jogada kept", jogada, 4'b0010);
    botoes_in = 4'b0000;
    wait_idle(20);

    // enable gating, then enable while held
    pulses = 0;
    habilita = 1'b0; botoes_in = 4'b0001;
    repeat (8) step();
    chk("gate estado", db_estado, 4'd0);
    chk("gate no pulse", pulses, 0);
    habilita = 1'b1;
    wait_pulse(12, n);
    chk("gate latency", n, 5);
    chk("gate jogada", jogada, 4'b0001);

    // release with short re-presses never completes the release window
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      botoes_in = (i % 4 == 3) ? 4'b0001 : 4'b0000;
      step();
    end
    chk("release held in espera", db_estado, 4'd3);
    chk("release no pulse", pulses, 0);
    botoes_in = 4'b0000;
    wait_idle(20);
    botoes_in = 4'b1000;
    wait_pulse(12, n);
    chk("new press latency", n, 7);
    chk("new press jogada", jogada, 4'b1000);
    botoes_in = 4'b0000;
    wait_idle(20);

    // asynchronous reset in the middle of filtering
    pulses = 0;
    botoes_in = 4'b0100;
    repeat (4) step();
    chk("pre-reset filtering", db_estado, 4'd1);
    #2 reset = 1'b0;
    #1;
    chk("async rst estado", db_estado, 4'd0);
    chk("async rst jogada", jogada, 4'b0000);
    chk("async rst feita", jogada_feita, 1'b0);
    chk("async rst multiplo", multiplo, 1'b0);
    botoes_in = 4'b0000;
    repeat (3) step();
    reset = 1'b1;
    repeat (10) step();
    chk("post-reset no pulse", pulses, 0);
    chk("post-reset estado", db_estado, 4'd0);

    chk("feita and multiplo exclusive", both, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/detector_jogada.md
# detector_jogada

Input-conditioning stage directly upstream of the game top level: takes the four raw push-buttons, synchronizes and debounces them, and emits a single-cycle `jogada_feita` pulse together with a registered one-hot button code. Its outputs feed the game's `jogada` strobe and `botoes` bus. Exactly one pulse is produced per physical press, and a new press is accepted only after a debounced release.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: cycles the synchronized input must stay stable (1 ms at 50 MHz). Must be ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: counter width (derived, do not override).

Ports:
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `botoes_in`  in  4  raw, asynchronous button levels, active-high.
- `habilita`  in  1  from control unit; new presses are accepted only while high.
- `jogada_feita`  out  1  one-cycle pulse, valid one-hot press.
- `jogada`  out  4  last valid one-hot code; holds until the next valid press.
- `multiplo`  out  1  one-cycle pulse, debounced press with more than one button.
- `db_estado`  out  4  FSM state code for the `hexa7seg` display.

## Operation
- Two-flop synchronizer on `botoes_in` produces `sinc[3:0]`. All logic uses `sinc` only.
- Capture register `amostra[3:0]` and counter `cnt[CNT_W-1:0]`.
- States (code on `db_estado`):
  - OCIOSO = 0: if `habilita` and `sinc != 0`, load `amostra <= sinc`, `cnt <= 0`, go to FILTRANDO. Otherwise stay.
  - FILTRANDO = 1: if `!habilita` or `sinc != amostra`, go to OCIOSO (bounce or abort; no output). Else if `cnt == DEBOUNCE_CYCLES-1`, go to EMITE. Else `cnt++`.
  - EMITE = 2: one cycle only.
    - If `amostra` is one-hot, `jogada_feita = 1`.
    - Otherwise `multiplo = 1` and `jogada` is unchanged.
    - Always go to ESPERA_SOLTAR with `cnt <= 0`.
  - ESPERA_SOLTAR = 3: if `sinc != 0`, `cnt <= 0`. Else if `cnt == DEBOUNCE_CYCLES-1`, go to OCIOSO. Else `cnt++`. `habilita` is ignored here.
- `jogada` loads `amostra` on the edge entering EMITE, and only if `amostra` is one-hot. It is therefore valid in the same cycle as `jogada_feita`.
- `jogada_feita` and `multiplo` are registered (Moore) outputs of EMITE. They are never high together.
- States 4–15 are unreachable. If entered, the FSM returns to OCIOSO on the next edge.

## Timing
- Reset values: state OCIOSO; `jogada` = 0000; `jogada_feita` = 0; `multiplo` = 0; `db_estado` = 0; synchronizer, `amostra`, and `cnt` all 0.
- Latency:
  - Raw edge → `sinc`: 2 edges.
  - `sinc` nonzero in OCIOSO → pulse high: exactly `DEBOUNCE_CYCLES + 1` edges.
  - Total raw → pulse: `DEBOUNCE_CYCLES + 3` edges.
- Pulse width: exactly 1 cycle.
- Minimum spacing between two pulses: `DEBOUNCE_CYCLES + 1` (filter) + 1 (emit) + `DEBOUNCE_CYCLES` (release).
- A held button yields exactly one pulse, however long it is held.
- A bounce shorter than `DEBOUNCE_CYCLES` during FILTRANDO yields no pulse. The restart happens from OCIOSO on the next nonzero `sinc`.
- If `habilita` falls during FILTRANDO, the press is discarded. If it rises while a button is already held, the press is accepted (debounce starts from OCIOSO).
- A second button added mid-filter changes `sinc` and restarts the filter. If the combination then stays stable, the result is `multiplo`.
- Asserting `reset` mid-operation returns to OCIOSO immediately and clears `jogada`.

## Structure
- Shared game package/include holds:
  - The state encodings OCIOSO/FILTRANDO/EMITE/ESPERA_SOLTAR (4-bit, reused by the display mux).
  - The default `DEBOUNCE_CYCLES`.
- One sub-module, `sincronizador_2ff`, parameterized by width (4 here), with asynchronous active-low reset. It is reusable for `iniciar`.
- The one-hot check is combinational inside the block: `amostra != 0 && (amostra & (amostra-1)) == 0`.

## Test plan
Run with `DEBOUNCE_CYCLES` = 4.
- Clean press: reset, `habilita` = 1, `botoes_in` = 0100 held 20 cycles, then 0 → one `jogada_feita` pulse exactly 7 edges after the raw change; `jogada` = 0100 and held; `db_estado` sequence 0, 1, 2, 3, 0.
- Bounce: 0010 for 2 cycles, 0 for 1, then 0010 stable → exactly one pulse; none during the glitch.
- Multiple buttons: 1001 stable for 10 cycles → `multiplo` 1-cycle pulse, no `jogada_feita`, `jogada` keeps its previous value.
- Enable gating: `habilita` = 0 with 0001 held → state stays 0, no pulse. Raise `habilita` while still held → pulse 5 edges later.
- Release debounce: after a pulse, release with 1-cycle re-presses of 0001 → no new pulse until 4 consecutive zero cycles, then a new 1000 press → `jogada` = 1000.
- Reset mid-filter: drive reset low during FILTRANDO → all outputs return to reset values asynchronously; no pulse after release of reset unless a new press is debounced.
